id_stage_rf: RTL
================

Name: id_stage_rf

Overview:
- Parametrised instruction-decode stage with integrated register file for the RV32I/RV32E core.
- Sits between the fetch stage and execute; replaces the single-generation decoder.
- Adds a valid/ready handshake, flush, writeback-to-read bypass, stall-coherent operands, AUIPC, link-value generation and illegal-instruction detection.
- Register writes come only from the writeback port; the decoder no longer writes link or LUI values itself.

Parameters:
- XLEN, 32, register and operand width.
- NREG, 32, number of architectural registers (32 = RV32I, 16 = RV32E).
- PC_W, 14, width of the fetch PC.
- PC_STEP, 1, PC increment per instruction (1 = word-addressed PC).
- BYPASS, 1, 1 = writeback-to-read forwarding enabled; 0 = none.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1, despite the name).
- flush_i  in  1  discard the held instruction (redirect from execute).
- in_valid_i  in  1  fetch presents an instruction.
- in_ready_o  out  1  stage can accept an instruction.
- instr_i  in  32  instruction word.
- pc_i  in  PC_W  PC of instr_i.
- wb_en_i  in  1  writeback enable.
- wb_rd_i  in  5  writeback destination register.
- wb_data_i  in  XLEN  writeback data.
- out_valid_o  out  1  decoded instruction valid.
- out_ready_i  in  1  execute accepts the instruction.
- imm_o  out  XLEN  sign-extended immediate.
- rdata1_o, rdata2_o  out  XLEN  operand values.
- rs1_o, rs2_o, rd_o  out  5  register indices.
- fmt_o  out  3  instruction format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- pc_o  out  PC_W  PC of the held instruction.
- link_o  out  PC_W  pc + PC_STEP, truncated to PC_W (wraps).
- illegal_o  out  1  unknown opcode, or a register index >= NREG.

Behaviour:
- Reset (rst_n = 1 at a clock edge):
  - all registers cleared to 0;
  - out_valid_o = 0, every output field = 0;
  - in_ready_o = 0 while rst_n = 1.
- Handshake:
  - in_ready_o = !rst_n && (!out_valid_o || out_ready_i).
  - Accept occurs when in_valid_i && in_ready_o && !flush_i. On accept, all output fields are registered and out_valid_o <= 1. Latency is 1 cycle.
  - If out_valid_o && out_ready_i and there is no accept, then out_valid_o <= 0.
  - While out_valid_o && !out_ready_i, all fields hold.
- Flush:
  - flush_i = 1 forces out_valid_o <= 0 and blocks any accept in that cycle.
  - Flush has priority over both accept and hold.
- Decode, by opcode:
  - 0110011 is R: imm = 0.
  - 0010011, 0000011 and 1100111 are I: imm = sext(instr[31:20]); rs2 = 0.
  - 0100011 is S: imm = sext({[31:25],[11:7]}); rd = 0.
  - 1100011 is B: 13-bit branch offset, LSB = 0; rd = 0.
  - 0110111 and 0010111 are U: imm = {[31:12], 12'b0}; rs1 = rs2 = 0.
  - 1101111 is J: 21-bit jump offset, LSB = 0; rs1 = rs2 = 0.
  - JAL and JALR keep rd from the instruction; the link value goes out on link_o and execute returns it via writeback.
  - Any other opcode: fmt = ILL, illegal_o = 1, all indices 0, imm = 0, rdata = 0.
  - If NREG = 16 and any used index has bit 4 set: illegal_o = 1 and the format is still decoded.
- Register file:
  - Write at the clock edge when wb_en_i && wb_rd_i != 0 && wb_rd_i < NREG.
  - x0 always reads 0; a write to x0 is ignored.
- Bypass on capture (BYPASS = 1): if wb_en_i && wb_rd_i == rsN && rsN != 0 in the accept cycle, rdataN_o takes wb_data_i.
- Stall coherence: while out_valid_o && !out_ready_i, a qualifying writeback to rs1_o or rs2_o (nonzero) updates that rdata output. This applies even when BYPASS = 0.
- Width rules: imm is sign-extended to XLEN, and XLEN >= 32 is required. Addition for link_o wraps modulo 2^PC_W.
- Simultaneous events:
  - rs1 = rs2 = wb_rd: both operands are bypassed.
  - A writeback in the reset cycle is ignored.
  - Flush plus writeback in the same cycle: the write still commits.

Decomposition:
- Shared package id_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - the fmt_e enum (R, I, S, B, U, J, ILL);
  - the function imm_gen(instr, fmt).
- One sub-module, id_regfile (NREG x XLEN, 2 read / 1 write, with x0 and bypass logic), instantiated by id_stage_rf.

Test Plan:
- Reset, then ADDI x5,x0,-3 (0xFFD00293) at pc = 0x010 → next cycle:
  - out_valid = 1, fmt = I, imm = 0xFFFFFFFD;
  - rd = 5, rs1 = 0, rdata1 = 0, link = 0x011.
- wb x7 = 0x1234 in the same cycle as accepting ADD x1,x7,x7 → rdata1 = rdata2 = 0x1234 (BYPASS = 1). With BYPASS = 0, both read the old value 0.
- out_ready = 0 for 3 cycles, with wb x7 = 0xBEEF during the stall → all fields hold, rdata for x7 becomes 0xBEEF, and in_ready stays 0 until out_ready = 1.
- JAL x1,+8 at pc = 0x3FFF (PC_W = 14) → fmt = J, imm = 8, rd = 1, link = 0x0000 (wrap).
- flush_i asserted with in_valid = 1 and out_valid = 1 → next cycle out_valid = 0 and the new instruction is not captured. Also, opcode 0x7F → illegal = 1, fmt = 7.
- NREG = 16: ADD x17,x1,x2 → illegal = 1. wb x0 = 0xFFFF followed by a read of x0 → 0. rst_n pulsed mid-stall → out_valid = 0 and all registers = 0.

Source files
------------

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcodes, instruction formats and immediate generation for the decode stage
package id_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_R:                     return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_J;
      default:                  return FMT_ILL;
    endcase
  endfunction

  // 32-bit sign-extended immediate; R and ILL carry no immediate
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{instr[31]}}, instr[31:20]};
      FMT_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   return {instr[31:12], 12'b0};
      FMT_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - NREG x XLEN register file, two read ports, one write port, x0 hardwired
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            wr_ok
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];

  assign wr_ok = we && (waddr != 5'd0) && (int'(waddr) < NREG);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  // Out-of-range indices read as zero; the decoder flags them illegal separately
  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a, input logic [XLEN-1:0] stored,
                                              input logic hit, input logic [XLEN-1:0] fwd);
    if (a == 5'd0 || int'(a) >= NREG) return '0;
    if (BYPASS != 0 && hit) return fwd;
    return stored;
  endfunction

  always_comb begin
    rdata1 = rd_port(raddr1, regs[raddr1[AW-1:0]], wr_ok && (waddr == raddr1), wdata);
    rdata2 = rd_port(raddr2, regs[raddr2[AW-1:0]], wr_ok && (waddr == raddr2), wdata);
  end

endmodule

// File: rtl/id_stage_rf.sv
// rtl/id_stage_rf.sv - decode stage with valid/ready handshake, flush and integrated register file
module id_stage_rf
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int PC_W    = 14,
  parameter int PC_STEP = 1,
  parameter int BYPASS  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      fmt_o,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] link_o,
  output logic            illegal_o
);

  fmt_e            fmt_d, fmt_q;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [31:0]     imm32_d;
  logic            ill_d;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic            wb_ok;
  logic            accept, stall;

  always_comb begin
    fmt_d = fmt_of(instr_i[6:0]);
    rs1_d = instr_i[19:15];
    rs2_d = instr_i[24:20];
    rd_d  = instr_i[11:7];
    case (fmt_d)
      FMT_I:        rs2_d = 5'd0;
      FMT_S, FMT_B: rd_d  = 5'd0;
      FMT_U, FMT_J: begin rs1_d = 5'd0; rs2_d = 5'd0; end
      FMT_ILL:      begin rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0; end
      default:      ;
    endcase
    imm32_d = imm_gen(instr_i, fmt_d);
    ill_d   = (fmt_d == FMT_ILL) || (int'(rs1_d) >= NREG) || (int'(rs2_d) >= NREG)
              || (int'(rd_d) >= NREG);
  end

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en_i),
    .waddr  (wb_rd_i),
    .wdata  (wb_data_i),
    .raddr1 (rs1_d),
    .raddr2 (rs2_d),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .wr_ok  (wb_ok)
  );

  assign in_ready_o = !rst_n && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign stall      = out_valid_o && !out_ready_i;
  assign fmt_o      = fmt_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_valid_o <= 1'b0;
      fmt_q       <= FMT_R;
      imm_o       <= '0;
      rdata1_o    <= '0;
      rdata2_o    <= '0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      rd_o        <= '0;
      pc_o        <= '0;
      link_o      <= '0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      fmt_q       <= fmt_d;
      imm_o       <= XLEN'($signed(imm32_d));
      rdata1_o    <= rf_rdata1;
      rdata2_o    <= rf_rdata2;
      rs1_o       <= rs1_d;
      rs2_o       <= rs2_d;
      rd_o        <= rd_d;
      pc_o        <= pc_i;
      link_o      <= pc_i + PC_W'(PC_STEP);
      illegal_o   <= ill_d;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end else if (stall) begin
      // Keep held operands coherent with writebacks that land while execute is stalled
      if (wb_ok && wb_rd_i == rs1_o) rdata1_o <= wb_data_i;
      if (wb_ok && wb_rd_i == rs2_o) rdata2_o <= wb_data_i;
    end
  end

endmodule
